// File: rtl/interface_hcsr04_param.sv
// HC-SR04 ultrasonic ranger: trigger pulse, echo timing, BCD centimetre result.
// Adds an echo timeout with an error flag, BCD saturation and a pronto/medir handshake.
module interface_hcsr04_param #(
    parameter int TRIGGER_CICLOS = 500,
    parameter int CICLOS_CM      = 2941,
    parameter int TIMEOUT_CICLOS = 1_500_000,
    parameter int N_DIGITOS      = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   medir,
    input  logic                   echo,
    output logic                   trigger,
    output logic [4*N_DIGITOS-1:0] medida,
    output logic                   pronto,
    output logic                   erro,
    output logic [3:0]             db_estado
);

    localparam int W  = 4 * N_DIGITOS;
    localparam int CW = (CICLOS_CM > 1) ? $clog2(CICLOS_CM) : 1;
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam int GW = (TRIGGER_CICLOS > 1) ? $clog2(TRIGGER_CICLOS) : 1;

    localparam logic [CW-1:0] C_ULT  = CW'(CICLOS_CM - 1);
    localparam logic [CW-1:0] C_MEIO = CW'(CICLOS_CM / 2);
    localparam logic [TW-1:0] T_ULT  = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [GW-1:0] G_ULT  = GW'(TRIGGER_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARACAO    = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDIDA        = 4'd4,
        ARMAZENAMENTO = 4'd5,
        FINAL_MEDIDA  = 4'd6,
        ERRO_TIMEOUT  = 4'd15
    } estado_t;

    estado_t       estado;
    logic [2:0]    sync;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] ccnt;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic [W-1:0]  cm;

    // A carry out of the top digit means all nines: hold instead of wrapping.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return c ? v : r;
    endfunction

    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync   <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync   <= {sync[1:0], echo};
            rise_q <= sync[1] & ~sync[2];
            fall_q <= ~sync[1] & sync[2];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= INICIAL;
            trigger <= 1'b0;
            medida  <= '0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
            ccnt    <= '0;
            tcnt    <= '0;
            gcnt    <= '0;
            cm      <= '0;
        end else begin
            unique case (estado)
                INICIAL: begin
                    if (medir) estado <= PREPARACAO;
                end
                PREPARACAO: begin
                    ccnt    <= '0;
                    tcnt    <= '0;
                    gcnt    <= '0;
                    cm      <= '0;
                    trigger <= 1'b1;
                    estado  <= ENVIA_TRIGGER;
                end
                ENVIA_TRIGGER: begin
                    if (gcnt == G_ULT) begin
                        trigger <= 1'b0;
                        tcnt    <= '0;
                        estado  <= ESPERA_ECHO;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                ESPERA_ECHO: begin
                    if (rise_q) begin
                        tcnt   <= '0;
                        estado <= MEDIDA;
                    end else if (tcnt == T_ULT) begin
                        pronto <= 1'b1;
                        erro   <= 1'b1;
                        estado <= ERRO_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                MEDIDA: begin
                    // The falling-edge cycle is still counted so width matches the pin.
                    if (ccnt == C_ULT) begin
                        ccnt <= '0;
                        cm   <= bcd_inc(cm);
                    end else begin
                        ccnt <= ccnt + 1'b1;
                    end
                    if (fall_q) begin
                        estado <= ARMAZENAMENTO;
                    end else if (tcnt == T_ULT) begin
                        pronto <= 1'b1;
                        erro   <= 1'b1;
                        estado <= ERRO_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ARMAZENAMENTO: begin
                    medida <= (ccnt >= C_MEIO) ? bcd_inc(cm) : cm;
                    pronto <= 1'b1;
                    erro   <= 1'b0;
                    estado <= FINAL_MEDIDA;
                end
                FINAL_MEDIDA: begin
                    if (medir) begin
                        pronto <= 1'b0;
                        estado <= PREPARACAO;
                    end
                end
                ERRO_TIMEOUT: begin
                    if (medir) begin
                        pronto <= 1'b0;
                        erro   <= 1'b0;
                        estado <= PREPARACAO;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

endmodule

// File: tb/tb_interface_hcsr04_param.sv
// Directed bench for interface_hcsr04_param with scaled-down timing constants.
// Echo widths are given in clock cycles; expected BCD values are hand-computed.
module tb_interface_hcsr04_param;

    localparam int TRIG = 5;
    localparam int CCM  = 10;
    localparam int TOUT = 12000;
    localparam int ND   = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          medir = 1'b0;
    logic          echo  = 1'b0;
    logic          trigger;
    logic [4*ND-1:0] medida;
    logic          pronto;
    logic          erro;
    logic [3:0]    db_estado;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        int          w;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[9];

    interface_hcsr04_param #(
        .TRIGGER_CICLOS(TRIG),
        .CICLOS_CM     (CCM),
        .TIMEOUT_CICLOS(TOUT),
        .N_DIGITOS     (ND)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .medir    (medir),
        .echo     (echo),
        .trigger  (trigger),
        .medida   (medida),
        .pronto   (pronto),
        .erro     (erro),
        .db_estado(db_estado)
    );

    always #10 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget,
                              input string nm);
        int n;
        n = 0;
        while (db_estado !== st && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (db_estado !== st) check({nm, " wait"}, db_estado, st);
    endtask

    task automatic pulse_medir();
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    task automatic echo_and_check(input int w, input logic [11:0] exp,
                                  input string nm);
        int lat;
        repeat (5) @(negedge clock);
        echo = 1'b1;
        repeat (w) @(negedge clock);
        echo = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!pronto && lat < 20);
        check({nm, " latency"}, lat, 5);
        check({nm, " medida"}, medida, exp);
        check({nm, " erro"}, erro, 0);
        check({nm, " estado"}, db_estado, 6);
    endtask

    task automatic do_meas(input int w, input logic [11:0] exp,
                           input string nm);
        pulse_medir();
        wait_state(4'd3, 50, nm);
        echo_and_check(w, exp, nm);
    endtask

    initial begin
        logic [15:0] seqv;
        logic [3:0]  last;
        int          ntrig;
        int          n;

        tbl[0] = '{1004,  12'h100};
        tbl[1] = '{1005,  12'h101};
        tbl[2] = '{995,   12'h100};
        tbl[3] = '{9,     12'h001};
        tbl[4] = '{4,     12'h000};
        tbl[5] = '{9995,  12'h999};
        tbl[6] = '{10500, 12'h999};
        tbl[7] = '{744,   12'h074};
        tbl[8] = '{745,   12'h075};

        repeat (100) @(negedge clock);
        check("rst trigger", trigger, 0);
        check("rst medida", medida, 0);
        check("rst pronto", pronto, 0);
        check("rst erro", erro, 0);
        check("rst estado", db_estado, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle estado", db_estado, 0);

        seqv  = 16'h0000;
        last  = 4'd0;
        ntrig = 0;
        medir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 4) medir = 1'b0;
            if (trigger) ntrig++;
            if (db_estado != last) begin
                seqv = {seqv[11:0], db_estado};
                last = db_estado;
            end
        end
        check("trigger width", ntrig, TRIG);
        check("state seq", seqv, 16'h0123);
        echo_and_check(1000, 12'h100, "first");

        for (int i = 0; i < 9; i++)
            do_meas(tbl[i].w, tbl[i].exp, $sformatf("vec%0d", i));

        pulse_medir();
        wait_state(4'd3, 50, "to");
        n = 0;
        while (db_estado == 4'd3 && n < TOUT + 10) begin
            n++;
            @(negedge clock);
        end
        check("to cycles", n, TOUT);
        check("to estado", db_estado, 4'hF);
        check("to pronto", pronto, 1);
        check("to erro", erro, 1);
        check("to medida", medida, 12'h075);
        pulse_medir();
        check("to clr pronto", pronto, 0);
        check("to clr erro", erro, 0);
        check("to clr estado", db_estado, 1);

        wait_state(4'd3, 50, "long");
        repeat (5) @(negedge clock);
        echo = 1'b1;
        wait_state(4'hF, TOUT + 100, "long");
        check("long erro", erro, 1);
        check("long pronto", pronto, 1);
        check("long medida", medida, 12'h075);
        echo = 1'b0;
        repeat (5) @(negedge clock);

        pulse_medir();
        wait_state(4'd3, 50, "rst");
        repeat (5) @(negedge clock);
        echo = 1'b1;
        wait_state(4'd4, 20, "rst");
        repeat (50) @(negedge clock);
        reset = 1'b1;
        medir = 1'b1;
        @(negedge clock);
        check("mid rst trigger", trigger, 0);
        check("mid rst medida", medida, 0);
        check("mid rst pronto", pronto, 0);
        check("mid rst erro", erro, 0);
        check("mid rst estado", db_estado, 0);
        reset = 1'b0;
        medir = 1'b0;
        @(negedge clock);
        pulse_medir();
        wait_state(4'd3, 50, "held echo");
        repeat (30) @(negedge clock);
        check("held echo ignored", db_estado, 3);
        echo = 1'b0;
        echo_and_check(745, 12'h075, "rerise");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
